// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester round-robin arbiter and sequencer in front of
// the single-port data memory. Each granted request becomes one memory
// access cycle (ACCESS) followed by a one-cycle acknowledge (DONE).
// Misaligned requests skip the memory and are acknowledged with err set.
// memReadData is the memory's negedge-updated read port, captured at the
// posedge that closes the ACCESS cycle.
module dmem_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  input  logic [DATA_W-1:0] memReadData,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memWriteData,
  output logic              memWrite,
  output logic              memRead
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic                r_gnt;
  logic                r_lastGnt;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_err;

  logic                w_grantValid;
  logic                w_grantIdx;
  logic                w_selWe;
  logic [ADDR_W-1:0]   w_selAddr;
  logic [DATA_W-1:0]   w_selWdata;
  logic                w_selAligned;
  logic                w_inAccess;
  logic                w_inDone;

  // Pick who is granted this cycle. From IDLE a tie goes to the requester
  // that was not served last; from DONE only the other requester counts,
  // since the one just served still has its req high.
  always_comb begin
    w_grantValid = 1'b0;
    w_grantIdx   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req0 && req1) begin
          w_grantValid = 1'b1;
          w_grantIdx   = ~r_lastGnt;
        end else if (req0) begin
          w_grantValid = 1'b1;
          w_grantIdx   = 1'b0;
        end else if (req1) begin
          w_grantValid = 1'b1;
          w_grantIdx   = 1'b1;
        end
      end
      DONE: begin
        if (r_gnt == 1'b0) begin
          if (req1) begin
            w_grantValid = 1'b1;
            w_grantIdx   = 1'b1;
          end
        end else begin
          if (req0) begin
            w_grantValid = 1'b1;
            w_grantIdx   = 1'b0;
          end
        end
      end
      default: begin
        w_grantValid = 1'b0;
        w_grantIdx   = 1'b0;
      end
    endcase
  end

  assign w_selWe      = w_grantIdx ? we1    : we0;
  assign w_selAddr    = w_grantIdx ? addr1  : addr0;
  assign w_selWdata   = w_grantIdx ? wdata1 : wdata0;
  assign w_selAligned = (w_selAddr[1:0] == 2'b00);

  // Next state: a grant goes to ACCESS when word aligned, or straight to
  // DONE to report the misalignment; ACCESS always lasts exactly one cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_grantValid) begin
          w_nextState = w_selAligned ? ACCESS : DONE;
        end else begin
          w_nextState = IDLE;
        end
      end
      ACCESS: begin
        w_nextState = DONE;
      end
      DONE: begin
        if (w_grantValid) begin
          w_nextState = w_selAligned ? ACCESS : DONE;
        end else begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register plus transaction latches. The request is latched on
  // grant so the requester's inputs are free afterwards; read data is
  // captured at the edge closing ACCESS. lastGnt starts at 1 so that
  // requester 0 wins the first tie after reset.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_state   <= IDLE;
      r_gnt     <= 1'b0;
      r_lastGnt <= 1'b1;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (r_state == ACCESS) begin
        r_rdata <= r_we ? '0 : memReadData;
        r_err   <= 1'b0;
      end
      if (r_state == DONE) begin
        r_lastGnt <= r_gnt;
      end
      if (w_grantValid) begin
        r_gnt   <= w_grantIdx;
        r_we    <= w_selWe;
        r_addr  <= w_selAddr;
        r_wdata <= w_selWdata;
        if (!w_selAligned) begin
          r_err   <= 1'b1;
          r_rdata <= '0;
        end
      end
    end
  end

  assign w_inAccess = (r_state == ACCESS);
  assign w_inDone   = (r_state == DONE);

  // Acknowledge and error are only visible in DONE, so err is never seen
  // without an ack.
  assign ack0  = w_inDone & ~r_gnt;
  assign ack1  = w_inDone &  r_gnt;
  assign err   = w_inDone &  r_err;
  assign rdata = r_rdata;

  // Memory strobes are gated by resetN so a reset landing on the closing
  // edge of ACCESS can never commit a write.
  assign memAddress   = w_inAccess ? r_addr  : '0;
  assign memWriteData = w_inAccess ? r_wdata : '0;
  assign memWrite     = w_inAccess &  r_we & resetN;
  assign memRead      = w_inAccess & ~r_we & resetN;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: drives the arbiter against a behavioural data memory
// (posedge write, negedge read) and checks every acknowledge against a
// scoreboard of expected {requester, rdata, err} records.
module tb_dmem_arbiter;

  logic        clock;
  logic        resetN;
  logic        req0, we0, req1, we1;
  logic [6:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        ack0, ack1, err;
  logic [31:0] rdata;
  logic [31:0] memReadData;
  logic [6:0]  memAddress;
  logic [31:0] memWriteData;
  logic        memWrite, memRead;

  dmem_arbiter #(.ADDR_W(7), .DATA_W(32)) dut (
    .clock(clock), .resetN(resetN),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .err(err), .memReadData(memReadData),
    .memAddress(memAddress), .memWriteData(memWriteData),
    .memWrite(memWrite), .memRead(memRead)
  );

  typedef struct {
    logic        who;
    logic [31:0] rdata;
    logic        err;
  } ack_t;

  typedef struct {
    logic        port;
    logic        we;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic        expErr;
  } vec_t;

  ack_t        sbq[$];
  vec_t        vecs[11];
  logic [31:0] model[32];
  logic [31:0] dmem[32];
  int          total = 0;
  int          bad   = 0;
  logic        sawAck0, sawAck1;
  int          wrCnt, rdCnt;
  logic [6:0]  strobeAddr;
  logic [31:0] strobeData;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] initWord(input int i);
    return 32'hA5A50000 | 32'(i);
  endfunction

  // Behavioural memory: write on posedge, read data updates on negedge.
  initial begin
    for (int i = 0; i < 32; i++) dmem[i] = initWord(i);
    memReadData = '0;
    forever begin
      @(clock);
      if (clock) begin
        if (memWrite) dmem[memAddress[6:2]] = memWriteData;
      end else begin
        if (memRead) memReadData = dmem[memAddress[6:2]];
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: sample at negedge, check invariants, track strobes and
  // pop the scoreboard on every acknowledge.
  task automatic step();
    ack_t e;
    @(negedge clock);
    sawAck0 = ack0;
    sawAck1 = ack1;
    checkOutput("ackExclusive", {31'b0, ack0 & ack1}, 32'd0);
    checkOutput("errWithoutAck", {31'b0, err & ~(ack0 | ack1)}, 32'd0);
    if (memWrite) begin
      wrCnt++;
      strobeAddr = memAddress;
      strobeData = memWriteData;
    end
    if (memRead) begin
      rdCnt++;
      strobeAddr = memAddress;
    end
    if (ack0 || ack1) begin
      if (sbq.size() == 0) begin
        checkOutput("spuriousAck", {30'b0, ack1, ack0}, 32'd0);
      end else begin
        e = sbq.pop_front();
        checkOutput("ackWho", {31'b0, ack1}, {31'b0, e.who});
        checkOutput("ackRdata", rdata, e.rdata);
        checkOutput("ackErr", {31'b0, err}, {31'b0, e.err});
      end
    end
  endtask

  task automatic doReset();
    resetN = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    step();
    step();
    resetN = 1'b1;
    step();
    checkOutput("rstOutputs", {20'b0, ack0, ack1, err, memWrite, memRead, memAddress}, 32'd0);
    checkOutput("rstWdata", memWriteData, 32'd0);
  endtask

  // Single isolated transaction driven from one table row.
  task automatic applyStimulus(input vec_t v);
    ack_t e;
    int   n;
    logic got;
    logic [31:0] expRd;
    expRd = (v.we || v.expErr) ? 32'd0 : model[v.addr[6:2]];
    e.who = v.port; e.rdata = expRd; e.err = v.expErr;
    sbq.push_back(e);
    if (v.port) begin
      req1 = 1'b1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
    end else begin
      req0 = 1'b1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
    end
    wrCnt = 0; rdCnt = 0;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      step();
      n++;
      if (v.port ? sawAck1 : sawAck0) got = 1'b1;
    end
    req0 = 1'b0; req1 = 1'b0;
    checkOutput("latency", 32'(n), v.expErr ? 32'd1 : 32'd2);
    checkOutput("writeStrobes", 32'(wrCnt), (v.we && !v.expErr) ? 32'd1 : 32'd0);
    checkOutput("readStrobes", 32'(rdCnt), (!v.we && !v.expErr) ? 32'd1 : 32'd0);
    if (!v.expErr) begin
      checkOutput("strobeAddr", {25'b0, strobeAddr}, {25'b0, v.addr});
      if (v.we) begin
        checkOutput("strobeData", strobeData, v.wdata);
        model[v.addr[6:2]] = v.wdata;
      end
    end
    step();
  endtask

  initial begin
    int   n;
    int   k;
    ack_t e;

    for (int i = 0; i < 32; i++) model[i] = initWord(i);
    vecs[0]  = '{1'b0, 1'b1, 7'h08, 32'hDEADBEEF, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 7'h08, 32'h00000000, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 7'h0C, 32'hCAFEF00D, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 7'h0C, 32'h00000000, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 7'h0A, 32'h00000000, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 7'h03, 32'h11112222, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 7'h00, 32'h00000000, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 7'h7C, 32'h00000000, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 7'h7C, 32'h0BADC0DE, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 7'h7C, 32'h00000000, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 7'h0C, 32'h00000000, 1'b0};

    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    wrCnt = 0; rdCnt = 0;
    doReset();

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

    // Simultaneous requests after reset: 0 first, then strict alternation.
    doReset();
    for (int i = 0; i < 6; i++) begin
      e.who   = i[0];
      e.rdata = i[0] ? model[3] : model[2];
      e.err   = 1'b0;
      sbq.push_back(e);
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 7'h08;
    req1 = 1'b1; we1 = 1'b0; addr1 = 7'h0C;
    n = 0; k = 0;
    while (k < 6 && n < 40) begin
      step();
      n++;
      if (sawAck0 || sawAck1) begin
        checkOutput("rrAckCycle", 32'(n), 32'(2 * (k + 1)));
        k++;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    checkOutput("rrAckCount", 32'(k), 32'd6);
    step();

    // Reset landing during a write ACCESS: write suppressed, no ack.
    req0 = 1'b1; we0 = 1'b1; addr0 = 7'h10; wdata0 = 32'h12345678;
    step();
    checkOutput("preRstWrite", {31'b0, memWrite}, 32'd1);
    resetN = 1'b0;
    #1;
    checkOutput("rstGatesWrite", {31'b0, memWrite}, 32'd0);
    req0 = 1'b0;
    step();
    step();
    resetN = 1'b1;
    step();
    step();
    applyStimulus('{1'b0, 1'b0, 7'h10, 32'h0, 1'b0});

    // req0 held one cycle past its ack is a second request.
    e.who = 1'b0; e.rdata = model[1]; e.err = 1'b0;
    sbq.push_back(e);
    sbq.push_back(e);
    req0 = 1'b1; we0 = 1'b0; addr0 = 7'h04;
    n = 0;
    while (!sawAck0 && n < 20) begin
      step();
      n++;
    end
    checkOutput("holdFirstLat", 32'(n), 32'd2);
    n = 0;
    do begin
      step();
      n++;
      if (n == 2) req0 = 1'b0;
    end while (!sawAck0 && n < 20);
    req0 = 1'b0;
    checkOutput("holdSecondLat", 32'(n), 32'd3);
    step();
    step();
    checkOutput("sbEmpty", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
